// File: rtl/analog_meas_pkg.sv
// Shared types and default thresholds for the analog measurement monitors.
// Thresholds assume the integrator's 7-bit quantised output and its 105-count full scale.
package analog_meas_pkg;

  typedef enum logic [1:0] {
    StWaitLow = 2'd0,
    StArmed   = 2'd1,
    StRising  = 2'd2,
    StHigh    = 2'd3
  } mon_state_e;

  localparam int unsigned FullScale     = 105;
  localparam int unsigned LowThDefault  = 21;   // ~20% of full scale
  localparam int unsigned HighThDefault = 84;   // ~80% of full scale
  localparam int unsigned CntWDefault   = 16;

endpackage

// File: rtl/rise_time_monitor.sv
// Hysteretic low-to-high transition detector that measures rise time in clk cycles.
// All outputs are registered; a condition sampled at an edge shows up right after it.
module rise_time_monitor
  import analog_meas_pkg::*;
#(
  parameter int unsigned WIDTH   = 7,
  parameter int unsigned LOW_TH  = LowThDefault,
  parameter int unsigned HIGH_TH = HighThDefault,
  parameter int unsigned CNT_W   = CntWDefault,
  parameter int unsigned TIMEOUT = 4000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] sample,
  output logic             meas_valid,
  output logic [CNT_W-1:0] meas_cycles,
  output logic             meas_timeout,
  output logic             level_hi,
  output logic [7:0]       rise_count
);

  localparam logic [WIDTH-1:0] LowTh      = WIDTH'(LOW_TH);
  localparam logic [WIDTH-1:0] HighTh     = WIDTH'(HIGH_TH);
  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

  mon_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] meas_cycles_q, meas_cycles_d;
  logic             meas_valid_q, meas_valid_d;
  logic             meas_timeout_q, meas_timeout_d;
  logic             level_hi_q, level_hi_d;
  logic [7:0]       rise_count_q, rise_count_d;

  logic is_low, is_high;

  assign is_low  = (sample <= LowTh);
  assign is_high = (sample >= HighTh);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    meas_cycles_d  = meas_cycles_q;
    meas_valid_d   = 1'b0;
    meas_timeout_d = 1'b0;
    level_hi_d     = level_hi_q;
    rise_count_d   = rise_count_q;

    if (!en) begin
      state_d    = StWaitLow;
      cnt_d      = '0;
      level_hi_d = 1'b0;
    end else begin
      unique case (state_q)
        // A power-up above the low threshold is never measured.
        StWaitLow: begin
          if (is_low) state_d = StArmed;
        end
        StArmed: begin
          if (is_high) begin
            state_d       = StHigh;
            meas_valid_d  = 1'b1;
            meas_cycles_d = '0;
            rise_count_d  = rise_count_q + 8'd1;
            level_hi_d    = 1'b1;
          end else if (!is_low) begin
            state_d = StRising;
            cnt_d   = CNT_W'(1);
          end
        end
        StRising: begin
          if (is_high) begin
            state_d       = StHigh;
            meas_valid_d  = 1'b1;
            meas_cycles_d = cnt_q;
            rise_count_d  = rise_count_q + 8'd1;
            level_hi_d    = 1'b1;
            cnt_d         = '0;
          end else if (is_low) begin
            state_d = StArmed;
            cnt_d   = '0;
          end else if (cnt_q == TimeoutCnt) begin
            state_d        = StWaitLow;
            meas_timeout_d = 1'b1;
            cnt_d          = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        // Mid-band samples keep level_hi set; only a low sample clears it.
        StHigh: begin
          if (is_low) begin
            state_d    = StArmed;
            level_hi_d = 1'b0;
          end
        end
        default: begin
          state_d = StWaitLow;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StWaitLow;
      cnt_q          <= '0;
      meas_cycles_q  <= '0;
      meas_valid_q   <= 1'b0;
      meas_timeout_q <= 1'b0;
      level_hi_q     <= 1'b0;
      rise_count_q   <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      meas_cycles_q  <= meas_cycles_d;
      meas_valid_q   <= meas_valid_d;
      meas_timeout_q <= meas_timeout_d;
      level_hi_q     <= level_hi_d;
      rise_count_q   <= rise_count_d;
    end
  end

  assign meas_valid   = meas_valid_q;
  assign meas_cycles  = meas_cycles_q;
  assign meas_timeout = meas_timeout_q;
  assign level_hi     = level_hi_q;
  assign rise_count   = rise_count_q;

endmodule

// File: tb/tb_rise_time_monitor.sv
// Directed bench for rise_time_monitor: a default instance plus a short-timeout
// instance sharing the same stimulus.
module tb_rise_time_monitor;

  logic       clk;
  logic       reset;
  logic       en;
  logic [6:0] sample;

  logic        meas_valid, meas_timeout, level_hi;
  logic [15:0] meas_cycles;
  logic [7:0]  rise_count;

  logic        to_valid, to_timeout, to_level_hi;
  logic [15:0] to_cycles;
  logic [7:0]  to_rise_count;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned n_valid, n_tmo, n_to_valid, n_to_tmo;
  int unsigned last_cycles;

  rise_time_monitor u_dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .sample       (sample),
    .meas_valid   (meas_valid),
    .meas_cycles  (meas_cycles),
    .meas_timeout (meas_timeout),
    .level_hi     (level_hi),
    .rise_count   (rise_count)
  );

  rise_time_monitor #(
    .TIMEOUT (20)
  ) u_dut_to (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .sample       (sample),
    .meas_valid   (to_valid),
    .meas_cycles  (to_cycles),
    .meas_timeout (to_timeout),
    .level_hi     (to_level_hi),
    .rise_count   (to_rise_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    n_valid    = 0;
    n_tmo      = 0;
    n_to_valid = 0;
    n_to_tmo   = 0;
  endtask

  // One clock edge, then sample outputs 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
    if (meas_valid) begin
      n_valid++;
      last_cycles = meas_cycles;
    end
    if (meas_timeout) n_tmo++;
    if (to_valid) n_to_valid++;
    if (to_timeout) n_to_tmo++;
  endtask

  task automatic drive(input int unsigned v);
    sample = 7'(v);
    tick();
  endtask

  initial begin
    reset  = 1'b1;
    en     = 1'b1;
    sample = '0;
    last_cycles = 0;
    clear_counts();
    #2 reset = 1'b0;
    #1;
    check("rst_valid", meas_valid, 0);
    check("rst_cycles", meas_cycles, 0);
    check("rst_timeout", meas_timeout, 0);
    check("rst_level_hi", level_hi, 0);
    check("rst_rise_count", rise_count, 0);
    tick();
    reset = 1'b1;

    // Ramp: armed at 0, t0 at 22, t1 at 84 -> 62 cycles.
    for (int v = 0; v <= 105; v++) begin
      drive(v);
      if (v == 84) check("ramp_valid_at_84", meas_valid, 1);
      if (v == 85) check("ramp_valid_drop", meas_valid, 0);
    end
    check("ramp_pulses", n_valid, 1);
    check("ramp_cycles", last_cycles, 62);
    check("ramp_level_hi", level_hi, 1);
    check("ramp_rise_count", rise_count, 1);
    check("ramp_timeouts", n_tmo, 0);

    // Hysteresis.
    clear_counts();
    drive(84); check("hyst_lvl_84", level_hi, 1);
    drive(50); check("hyst_lvl_50", level_hi, 1);
    drive(83); check("hyst_lvl_83", level_hi, 1);
    drive(20); check("hyst_lvl_20", level_hi, 0);
    drive(60); check("hyst_lvl_60", level_hi, 0);
    drive(90);
    check("hyst_valid", meas_valid, 1);
    check("hyst_cycles", meas_cycles, 1);
    check("hyst_lvl_90", level_hi, 1);
    check("hyst_rise_count", rise_count, 2);
    check("hyst_pulses", n_valid, 1);

    // Step from armed.
    drive(10); check("step_armed_lvl", level_hi, 0);
    drive(100);
    check("step_valid", meas_valid, 1);
    check("step_cycles", meas_cycles, 0);
    check("step_rise_count", rise_count, 3);
    tick();
    check("step_valid_drop", meas_valid, 0);

    // Abort then timeout.
    drive(10);
    clear_counts();
    for (int i = 0; i < 10; i++) drive(50);
    drive(5);
    check("abort_pulses", n_valid, 0);
    check("abort_to_pulses", n_to_valid, 0);
    check("abort_timeouts", n_to_tmo, 0);
    check("abort_cycles_held", meas_cycles, 0);
    sample = 7'd50;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (i == 19) check("tmo_early", to_timeout, 0);
      if (i == 20) check("tmo_pulse", to_timeout, 1);
      if (i == 20) check("tmo_not_valid", to_valid, 0);
    end
    check("tmo_count", n_to_tmo, 1);
    check("tmo_no_valid", n_to_valid, 0);
    check("tmo_default_none", n_tmo, 0);

    // Enable drop mid-rise.
    drive(5); drive(50); drive(90);
    check("en_pre_cycles", meas_cycles, 1);
    check("en_pre_rise_count", rise_count, 4);
    drive(5); drive(50); drive(50);
    clear_counts();
    en = 1'b0;
    drive(90);
    check("en_off_valid", n_valid, 0);
    check("en_off_cycles", meas_cycles, 1);
    check("en_off_rise_count", rise_count, 4);
    check("en_off_level_hi", level_hi, 0);
    en = 1'b1;
    drive(90);
    check("en_waitlow_valid", n_valid, 0);
    check("en_waitlow_level_hi", level_hi, 0);

    // Asynchronous reset mid-rise.
    drive(5); drive(50); drive(60);
    #3 reset = 1'b0;
    #1;
    check("areset_cycles", meas_cycles, 0);
    check("areset_rise_count", rise_count, 0);
    check("areset_level_hi", level_hi, 0);
    check("areset_valid", meas_valid, 0);
    tick();
    reset = 1'b1;
    clear_counts();
    drive(90);
    check("areset_no_pulse", n_valid, 0);

    // 256 step rises wrap rise_count.
    for (int i = 0; i < 256; i++) begin
      drive(10);
      drive(100);
      if (i == 254) check("wrap_255", rise_count, 255);
    end
    check("wrap_zero", rise_count, 0);
    check("wrap_pulses", n_valid, 256);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
